im_loader_mem: RTL and testbench
================================

// Module: im_loader_mem
// PURPOSE
//  Instruction-memory responder for the single-cycle CPU's fetch port (IM_Address in, Instruction out).
//  After reset it first fills its word array from a byte-serial load stream.
//  It holds the CPU in reset (cpu_rst) until the load completes, then serves fetches combinationally.
//  It sits beside the CPU top and drives the CPU's clk/rst domain.
// PARAMETERS
//  data_size  32  instruction word width (bits); fixed at 32 (four load bytes per word)
//  mem_size   16  width of IM_Address (word address from the CPU)
//  addr_bits  10  implemented words = 2**addr_bits; addr_bits <= mem_size
// PORTS
//  clk          in   1              single clock, rising edge
//  rst          in   1              asynchronous, active-high reset
//  IM_Address   in   mem_size       word address from CPU fetch
//  Instruction  out  data_size      fetched word
//  ld_valid     in   1              load byte valid
//  ld_ready     out  1              load byte accepted when ld_valid & ld_ready
//  ld_byte      in   8              load data, big-endian within word
//  ld_last      in   1              qualifies final byte of image
//  cpu_rst      out  1              held high while loading; drives CPU rst
//  ld_count     out  addr_bits+1    words written since load start
//  ld_error     out  1              sticky: image exceeded 2**addr_bits words
//  ld_reload    in   1              only with IM_RELOAD_EN: request reload
// BEHAVIOUR
//  - FSM states LOAD, RUN. rst -> LOAD; rst high forces LOAD asynchronously.
//  - Reset values: cpu_rst=1, ld_ready=1, ld_count=0, ld_error=0, Instruction=0.
//  - Array contents are not reset.
//  - LOAD: ld_ready=1, cpu_rst=1, Instruction=0 (NOP).
//  - Each accepted byte shifts into the word assembler; the first byte of a word goes to [31:24].
//  - A 2-bit byte counter tracks position in the word.
//  - On the 4th byte: write word to mem[waddr] at that clock edge, waddr++, ld_count++, byte counter=0.
//  - ld_last on an accepted byte: the (possibly partial) word is written in the same edge.
//    Unfilled low bytes are zero-padded. The FSM then goes to RUN.
//  - ld_last on a complete-word boundary: that 4th byte's word is written normally.
//    No extra write occurs.
//  - Overflow: a word completed while waddr == 2**addr_bits is dropped and ld_error set.
//    ld_error stays set until rst; ld_count saturates at 2**addr_bits.
//    ld_last still moves to RUN.
//  - ld_valid low: no state change; the byte counter and assembler hold.
//  - RUN: ld_ready=0; bytes are ignored; cpu_rst=0 from the cycle after the ld_last edge.
//    Instruction = mem[IM_Address[addr_bits-1:0]], combinational (zero-latency, as single-cycle fetch requires).
//    Instruction=0 if IM_Address[mem_size-1:addr_bits] != 0.
//  - Reset mid-load: waddr, byte counter, ld_count cleared; partial word discarded.
//    Previously written words remain until overwritten.
//  - cpu_rst and ld_ready are decoded from the registered state (glitch-free, no input-to-output path).
// CONFIGURATION
//  IM_RELOAD_EN defined:
//   - Port ld_reload exists.
//   - A high sample in RUN moves to LOAD at the next edge: cpu_rst=1, ld_count=0, ld_error=0, waddr=0.
//   - Ignored in LOAD.
//  IM_RELOAD_EN undefined:
//   - Port ld_reload absent.
//   - Only rst starts a load; RUN is terminal until rst.
// TESTING
//  1. rst, then bytes 20 08 00 05 00 00 00 00(last) -> mem[0]=0x20080005, mem[1]=0, ld_count=2.
//     cpu_rst falls the cycle after last; IM_Address=0 -> Instruction=0x20080005.
//  2. rst, bytes AA BB CC(last) -> mem[0]=0xAABBCC00, ld_count=1, RUN entered.
//  3. bytes 11 22, ld_valid low 5 cycles, 33 44(last) -> mem[0]=0x11223344; counters frozen during gap.
//  4. addr_bits=2, 20 bytes, last on byte 20 -> ld_error=1, ld_count=4, mem[0..3] hold first 16 bytes.
//  5. rst pulse after 6 bytes -> ld_count=0, cpu_rst=1; next 4 bytes land in mem[0].
//     IM_Address=0x0400 (addr_bits=10) in RUN -> Instruction=0.
//  6. IM_RELOAD_EN: ld_reload in RUN -> next cycle cpu_rst=1, ld_ready=1, ld_count=0, Instruction=0.
//     A new 4-byte image then loads into mem[0].

Source files
------------

// File: rtl/im_loader_mem_if.sv
// Load-stream handshake and fetch bus shared by im_loader_mem and its driver.
interface im_loader_mem_if #(
    parameter int data_size = 32,
    parameter int mem_size  = 16
);
    logic                 ld_valid;
    logic                 ld_ready;
    logic [7:0]           ld_byte;
    logic                 ld_last;
    logic [mem_size-1:0]  IM_Address;
    logic [data_size-1:0] Instruction;

    modport master (
        output ld_valid, ld_byte, ld_last, IM_Address,
        input  ld_ready, Instruction
    );

    modport slave (
        input  ld_valid, ld_byte, ld_last, IM_Address,
        output ld_ready, Instruction
    );
endinterface

// File: rtl/im_loader_mem.sv
// Instruction memory that fills itself from a byte stream, holding the CPU in reset meanwhile.
// Optional feature: define IM_RELOAD_EN to add the ld_reload port (reload from RUN).
module im_loader_mem #(
    parameter int data_size = 32,
    parameter int mem_size  = 16,
    parameter int addr_bits = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    im_loader_mem_if.slave       bus,
    output logic                 cpu_rst,
    output logic [addr_bits:0]   ld_count,
    output logic                 ld_error
`ifdef IM_RELOAD_EN
    ,
    input  logic                 ld_reload
`endif
);
    localparam int WORDS = 1 << addr_bits;
    localparam logic [addr_bits:0] FULL = (addr_bits + 1)'(WORDS);

    typedef enum logic {LOAD, RUN} state_e;

    state_e               state_q, state_d;
    logic [addr_bits:0]   waddr_q, waddr_d;
    logic [1:0]           bcnt_q, bcnt_d;
    logic [data_size-1:0] asm_q, asm_d;
    logic                 err_q, err_d;
    logic [data_size-1:0] merged;
    logic                 accept;
    logic                 we;
    logic                 hi_zero;

    logic [data_size-1:0] mem [WORDS];

    always_comb begin
        merged = asm_q;
        unique case (bcnt_q)
            2'd0:    merged[31:24] = bus.ld_byte;
            2'd1:    merged[23:16] = bus.ld_byte;
            2'd2:    merged[15:8]  = bus.ld_byte;
            default: merged[7:0]   = bus.ld_byte;
        endcase
    end

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        err_d   = err_q;
        we      = 1'b0;
        accept  = (state_q == LOAD) && bus.ld_valid;
        if (accept) begin
            asm_d  = merged;
            bcnt_d = bcnt_q + 2'd1;
            // a short final word is written with its low bytes still zero
            if (bcnt_q == 2'd3 || bus.ld_last) begin
                asm_d  = '0;
                bcnt_d = '0;
                if (waddr_q == FULL) begin
                    err_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    waddr_d = waddr_q + 1'b1;
                end
                if (bus.ld_last) begin
                    state_d = RUN;
                end
            end
        end
`ifdef IM_RELOAD_EN
        if (state_q == RUN && ld_reload) begin
            state_d = LOAD;
            waddr_d = '0;
            bcnt_d  = '0;
            asm_d   = '0;
            err_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            waddr_q <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr_q[addr_bits-1:0]] <= merged;
        end
    end

    assign hi_zero = (bus.IM_Address >> addr_bits) == '0;

    // fetch is combinational so the single-cycle CPU sees data in the same cycle
    assign bus.Instruction = (state_q == RUN && hi_zero)
                           ? mem[bus.IM_Address[addr_bits-1:0]]
                           : '0;

    assign bus.ld_ready = (state_q == LOAD);
    assign cpu_rst      = (state_q == LOAD);
    assign ld_count     = waddr_q;
    assign ld_error     = err_q;
endmodule

// File: tb/tb_im_loader_mem.sv
// Bench for im_loader_mem: directed and randomized image loads against a byte-image model.
// Reload checks compile in when IM_RELOAD_EN is defined.
module tb_im_loader_mem;
    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    im_loader_mem_if #(.data_size(32), .mem_size(16)) bus_a ();
    im_loader_mem_if #(.data_size(32), .mem_size(16)) bus_b ();

    logic        cpu_rst_a, cpu_rst_b;
    logic        err_a, err_b;
    logic [10:0] cnt_a;
    logic [2:0]  cnt_b;
`ifdef IM_RELOAD_EN
    logic        reload_a = 1'b0;
    logic        reload_b = 1'b0;
`endif

    im_loader_mem #(.data_size(32), .mem_size(16), .addr_bits(10)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_a),
        .cpu_rst  (cpu_rst_a),
        .ld_count (cnt_a),
        .ld_error (err_a)
`ifdef IM_RELOAD_EN
        ,
        .ld_reload(reload_a)
`endif
    );

    im_loader_mem #(.data_size(32), .mem_size(16), .addr_bits(2)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_b),
        .cpu_rst  (cpu_rst_b),
        .ld_count (cnt_b),
        .ld_error (err_b)
`ifdef IM_RELOAD_EN
        ,
        .ld_reload(reload_b)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_a [1024];
    bit          known_a [1024];
    logic [31:0] exp_b [4];
    bit          known_b [4];

    // Image model: byte k of the image is byte (k%4) of word k/4, MSB first.
    task automatic model_load(input bit sel, input bq_t q, input bit done);
        int n;
        int words;
        logic [31:0] w;
        n = q.size();
        words = done ? (n + 3) / 4 : n / 4;
        for (int i = 0; i < words; i++) begin
            w = '0;
            for (int j = 0; j < 4; j++)
                if (4 * i + j < n) w[31 - 8 * j -: 8] = q[4 * i + j];
            if (!sel) begin
                if (i < 1024) begin
                    exp_a[i] = w;
                    known_a[i] = 1'b1;
                end
            end else if (i < 4) begin
                exp_b[i] = w;
                known_b[i] = 1'b1;
            end
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input bit last);
        @(negedge clk);
        if (!sel) begin
            bus_a.ld_valid = 1'b1;
            bus_a.ld_byte  = b;
            bus_a.ld_last  = last;
        end else begin
            bus_b.ld_valid = 1'b1;
            bus_b.ld_byte  = b;
            bus_b.ld_last  = last;
        end
        @(posedge clk);
        #1;
        bus_a.ld_valid = 1'b0;
        bus_a.ld_last  = 1'b0;
        bus_b.ld_valid = 1'b0;
        bus_b.ld_last  = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [15:0] a, output logic [31:0] d);
        if (!sel) bus_a.IM_Address = a;
        else bus_b.IM_Address = a;
        #1;
        d = sel ? bus_b.Instruction : bus_a.Instruction;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #3;
        rst = 1'b1;
        #1;
        rd(1'b0, 16'h0000, d);
        checks++;
        if (cpu_rst_a !== 1'b1 || bus_a.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: cpu_rst=%b ready=%b want 1 1", cpu_rst_a, bus_a.ld_ready);
        end
        checks++;
        if (cnt_a !== 11'd0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: count=%0d err=%b want 0 0", cnt_a, err_a);
        end
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_instr: got %h want 00000000", d);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bq_t q;
        logic [31:0] d;
        q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus_a.ld_ready !== 1'b1 || cpu_rst_a !== 1'b1) begin
                errors++;
                $display("FAIL basic_load_ctrl[%0d]: ready=%b cpu_rst=%b want 1 1", i, bus_a.ld_ready, cpu_rst_a);
            end
            send(1'b0, q[i], i == 7);
            if (i == 3) begin
                checks++;
                if (cnt_a !== 11'd1) begin
                    errors++;
                    $display("FAIL basic_cnt_mid: got %0d want 1", cnt_a);
                end
            end
        end
        model_load(1'b0, q, 1'b1);
        checks++;
        if (cpu_rst_a !== 1'b0 || bus_a.ld_ready !== 1'b0 || cnt_a !== 11'd2) begin
            errors++;
            $display("FAIL basic_run: cpu_rst=%b ready=%b count=%0d want 0 0 2", cpu_rst_a, bus_a.ld_ready, cnt_a);
        end
        for (int i = 0; i < 2; i++) begin
            rd(1'b0, 16'(i), d);
            checks++;
            if (d !== exp_a[i]) begin
                errors++;
                $display("FAIL basic_mem[%0d]: got %h want %h", i, d, exp_a[i]);
            end
        end
    endtask

    task automatic test_partial();
        bq_t q;
        logic [31:0] d;
        do_reset();
        q = '{8'hAA, 8'hBB, 8'hCC};
        for (int i = 0; i < 3; i++) send(1'b0, q[i], i == 2);
        model_load(1'b0, q, 1'b1);
        rd(1'b0, 16'h0000, d);
        checks++;
        if (d !== exp_a[0] || cnt_a !== 11'd1 || cpu_rst_a !== 1'b0) begin
            errors++;
            $display("FAIL partial: word=%h count=%0d cpu_rst=%b want %h 1 0", d, cnt_a, cpu_rst_a, exp_a[0]);
        end
    endtask

    task automatic test_gap();
        bq_t q;
        logic [31:0] d;
        do_reset();
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send(1'b0, q[0], 1'b0);
        send(1'b0, q[1], 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (cnt_a !== 11'd0 || cpu_rst_a !== 1'b1) begin
                errors++;
                $display("FAIL gap_hold[%0d]: count=%0d cpu_rst=%b want 0 1", c, cnt_a, cpu_rst_a);
            end
        end
        send(1'b0, q[2], 1'b0);
        send(1'b0, q[3], 1'b1);
        model_load(1'b0, q, 1'b1);
        rd(1'b0, 16'h0000, d);
        checks++;
        if (d !== exp_a[0] || cnt_a !== 11'd1) begin
            errors++;
            $display("FAIL gap_word: word=%h count=%0d want %h 1", d, cnt_a, exp_a[0]);
        end
    endtask

    task automatic test_random();
        bq_t q;
        logic [31:0] d;
        int n;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            q = {};
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                send(1'b0, q[i], i == n - 1);
            end
            model_load(1'b0, q, 1'b1);
            for (int i = 0; i < 3; i++) send(1'b0, 8'($urandom), 1'b1);
            checks++;
            if (cnt_a !== 11'((n + 3) / 4) || err_a !== 1'b0 || bus_a.ld_ready !== 1'b0) begin
                errors++;
                $display("FAIL rand_status[%0d]: count=%0d err=%b ready=%b want %0d 0 0", r, cnt_a, err_a, bus_a.ld_ready, (n + 3) / 4);
            end
            for (int i = 0; i < 12; i++) begin
                if (known_a[i]) begin
                    rd(1'b0, 16'(i), d);
                    checks++;
                    if (d !== exp_a[i]) begin
                        errors++;
                        $display("FAIL rand_mem[%0d][%0d]: got %h want %h", r, i, d, exp_a[i]);
                    end
                end
            end
            rd(1'b0, 16'h0400 | 16'($urandom_range(0, 1023)) | (16'($urandom) & 16'hFC00), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL rand_oob[%0d]: got %h want 00000000", r, d);
            end
        end
    endtask

    task automatic test_rst_midload();
        bq_t q;
        logic [31:0] d;
        do_reset();
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) send(1'b0, q[i], 1'b0);
        model_load(1'b0, q, 1'b0);
        checks++;
        if (cnt_a !== 11'd1) begin
            errors++;
            $display("FAIL midload_cnt: got %0d want 1", cnt_a);
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        checks++;
        if (cnt_a !== 11'd0 || cpu_rst_a !== 1'b1 || bus_a.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL midload_rst: count=%0d cpu_rst=%b ready=%b want 0 1 1", cnt_a, cpu_rst_a, bus_a.ld_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        q = {};
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) send(1'b0, q[i], i == 3);
        model_load(1'b0, q, 1'b1);
        for (int i = 0; i < 2; i++) begin
            rd(1'b0, 16'(i), d);
            checks++;
            if (d !== exp_a[i]) begin
                errors++;
                $display("FAIL midload_mem[%0d]: got %h want %h", i, d, exp_a[i]);
            end
        end
        rd(1'b0, 16'h0400, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL midload_oob: got %h want 00000000", d);
        end
    endtask

    task automatic test_overflow();
        bq_t q;
        logic [31:0] d;
        do_reset();
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
        for (int i = 0; i < 20; i++) begin
            send(1'b1, q[i], i == 19);
            if (i == 15) begin
                checks++;
                if (cnt_b !== 3'd4 || err_b !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full: count=%0d err=%b want 4 0", cnt_b, err_b);
                end
            end
        end
        model_load(1'b1, q, 1'b1);
        checks++;
        if (cnt_b !== 3'd4 || err_b !== 1'b1 || cpu_rst_b !== 1'b0) begin
            errors++;
            $display("FAIL ovf_status: count=%0d err=%b cpu_rst=%b want 4 1 0", cnt_b, err_b, cpu_rst_b);
        end
        for (int i = 0; i < 4; i++) begin
            rd(1'b1, 16'(i), d);
            checks++;
            if (d !== exp_b[i]) begin
                errors++;
                $display("FAIL ovf_mem[%0d]: got %h want %h", i, d, exp_b[i]);
            end
        end
        rd(1'b1, 16'h0004, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL ovf_oob: got %h want 00000000", d);
        end
        do_reset();
        checks++;
        if (err_b !== 1'b0 || cnt_b !== 3'd0) begin
            errors++;
            $display("FAIL ovf_clear: err=%b count=%0d want 0 0", err_b, cnt_b);
        end
    endtask

`ifdef IM_RELOAD_EN
    task automatic test_reload();
        bq_t q;
        logic [31:0] d;
        do_reset();
        send(1'b0, 8'h5A, 1'b1);
        @(negedge clk);
        reload_a = 1'b1;
        @(posedge clk);
        #1;
        reload_a = 1'b0;
        rd(1'b0, 16'h0000, d);
        checks++;
        if (cpu_rst_a !== 1'b1 || bus_a.ld_ready !== 1'b1 || cnt_a !== 11'd0 || err_a !== 1'b0 || d !== 32'h0) begin
            errors++;
            $display("FAIL reload_state: cpu_rst=%b ready=%b count=%0d err=%b instr=%h want 1 1 0 0 0", cpu_rst_a, bus_a.ld_ready, cnt_a, err_a, d);
        end
        q = {};
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                @(negedge clk);
                reload_a = 1'b1;
                @(posedge clk);
                #1;
                reload_a = 1'b0;
            end
            send(1'b0, q[i], i == 3);
        end
        model_load(1'b0, q, 1'b1);
        rd(1'b0, 16'h0000, d);
        checks++;
        if (d !== exp_a[0] || cnt_a !== 11'd1 || cpu_rst_a !== 1'b0) begin
            errors++;
            $display("FAIL reload_word: word=%h count=%0d cpu_rst=%b want %h 1 0", d, cnt_a, cpu_rst_a, exp_a[0]);
        end
    endtask
`endif

    initial begin
        bus_a.ld_valid = 1'b0;
        bus_a.ld_byte = '0;
        bus_a.ld_last = 1'b0;
        bus_a.IM_Address = '0;
        bus_b.ld_valid = 1'b0;
        bus_b.ld_byte = '0;
        bus_b.ld_last = 1'b0;
        bus_b.IM_Address = '0;
        test_reset();
        test_basic();
        test_partial();
        test_gap();
        test_random();
        test_rst_midload();
        test_overflow();
`ifdef IM_RELOAD_EN
        test_reload();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
